// File: rtl/divisivel_serial.sv
// Serial divisibility checker: takes a word MSB first and tracks the running remainder
// modulo DIVISOR, then reports divisibility and the final remainder on a one-cycle valid pulse.
module divisivel_serial #(
  parameter int DIVISOR   = 3,
  parameter int WORD_BITS = 3,
  localparam int RW = ($clog2(DIVISOR) > 1) ? $clog2(DIVISOR) : 1,
  localparam int CW = ($clog2(WORD_BITS + 1) > 1) ? $clog2(WORD_BITS + 1) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          ready,
  input  logic          bit_in,
  output logic          busy,
  output logic          valid,
  output logic          out,
  output logic [RW-1:0] remainder
);

  if (DIVISOR < 2 || WORD_BITS < 1) begin : g_param_check
    $error("divisivel_serial: DIVISOR must be >= 2 and WORD_BITS >= 1");
  end

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [RW-1:0] rem_q, rem_d;
  logic          valid_q, valid_d;
  logic          out_q, out_d;
  logic [RW-1:0] remainder_q, remainder_d;

  // One shift-and-reduce step; since r < DIVISOR, 2r+b < 2*DIVISOR needs at most one subtract.
  function automatic logic [RW-1:0] mod_step(input logic [RW-1:0] r, input logic b);
    logic [RW:0] t;
    t = {r, b};
    if (t >= (RW+1)'(DIVISOR)) begin
      t = t - (RW+1)'(DIVISOR);
    end
    return t[RW-1:0];
  endfunction

  logic [RW-1:0] rem_base;
  logic [CW-1:0] count_base;
  logic [RW-1:0] rem_nxt;
  logic [CW-1:0] count_nxt;

  always_comb begin
    rem_base   = (state_q == StIdle) ? '0 : rem_q;
    count_base = (state_q == StIdle) ? '0 : count_q;
    rem_nxt    = mod_step(rem_base, bit_in);
    count_nxt  = count_base + CW'(1);
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    valid_d     = 1'b0;
    out_d       = out_q;
    remainder_d = remainder_q;

    if (clear) begin
      state_d = StIdle;
      count_d = '0;
      rem_d   = '0;
    end else if (ready) begin
      unique case (state_q)
        StIdle, StAccum: begin
          if (count_nxt == CW'(WORD_BITS)) begin
            state_d     = StIdle;
            count_d     = '0;
            rem_d       = '0;
            valid_d     = 1'b1;
            out_d       = (rem_nxt == '0);
            remainder_d = rem_nxt;
          end else begin
            state_d = StAccum;
            count_d = count_nxt;
            rem_d   = rem_nxt;
          end
        end
        default: begin
          state_d = StIdle;
          count_d = '0;
          rem_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      count_q     <= '0;
      rem_q       <= '0;
      valid_q     <= 1'b0;
      out_q       <= 1'b0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      valid_q     <= valid_d;
      out_q       <= out_d;
      remainder_q <= remainder_d;
    end
  end

  assign busy      = (state_q == StAccum);
  assign valid     = valid_q;
  assign out       = out_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_divisivel_serial.sv
// Bench for divisivel_serial: four instances with different DIVISOR/WORD_BITS, driven by a
// vector table and hand sequences, with results checked through an expected-result queue.
module tb_divisivel_serial;

  logic       clk;
  logic       rst_n;
  logic [3:0] rdy;
  logic [3:0] bin;
  logic [3:0] clr;
  logic [3:0] busy;
  logic [3:0] valid;
  logic [3:0] outv;
  logic [0:0] rem0;
  logic [1:0] rem1;
  logic [2:0] rem2;
  logic [2:0] rem3;
  int         remv[4];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int inst;
    int exp_out;
    int exp_rem;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int inst;
    int word;
    int nbits;
    int gap;
    int exp_out;
    int exp_rem;
  } vec_t;
  vec_t tbl[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  divisivel_serial #(.DIVISOR(2), .WORD_BITS(3)) u_d2 (
    .clk(clk), .reset(rst_n), .clear(clr[0]), .ready(rdy[0]), .bit_in(bin[0]),
    .busy(busy[0]), .valid(valid[0]), .out(outv[0]), .remainder(rem0));
  divisivel_serial #(.DIVISOR(3), .WORD_BITS(3)) u_d3 (
    .clk(clk), .reset(rst_n), .clear(clr[1]), .ready(rdy[1]), .bit_in(bin[1]),
    .busy(busy[1]), .valid(valid[1]), .out(outv[1]), .remainder(rem1));
  divisivel_serial #(.DIVISOR(5), .WORD_BITS(8)) u_d5 (
    .clk(clk), .reset(rst_n), .clear(clr[2]), .ready(rdy[2]), .bit_in(bin[2]),
    .busy(busy[2]), .valid(valid[2]), .out(outv[2]), .remainder(rem2));
  divisivel_serial #(.DIVISOR(7), .WORD_BITS(6)) u_d7 (
    .clk(clk), .reset(rst_n), .clear(clr[3]), .ready(rdy[3]), .bit_in(bin[3]),
    .busy(busy[3]), .valid(valid[3]), .out(outv[3]), .remainder(rem3));

  always_comb begin
    remv[0] = int'(rem0);
    remv[1] = int'(rem1);
    remv[2] = int'(rem2);
    remv[3] = int'(rem3);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every valid pulse must match the oldest outstanding expected result.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst_n && valid[i]) begin
        if (sb.size() == 0) begin
          check("spurious_valid", i, -1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_inst", i, e.inst);
          check("sb_out", int'(outv[i]), e.exp_out);
          check("sb_rem", remv[i], e.exp_rem);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input int inst, input int word, input int nbits, input int gap,
                           input int exp_out, input int exp_rem);
    exp_t e;
    e.inst    = inst;
    e.exp_out = exp_out;
    e.exp_rem = exp_rem;
    sb.push_back(e);
    for (int k = nbits - 1; k >= 0; k--) begin
      rdy[inst] = 1'b1;
      bin[inst] = word[k];
      tick();
    end
    check("valid_after_last_bit", int'(valid[inst]), 1);
    if (gap > 0) begin
      rdy[inst] = 1'b0;
      bin[inst] = 1'bx;
      tick();
      check("valid_one_cycle", int'(valid[inst]), 0);
      repeat (gap - 1) tick();
    end
  endtask

  initial begin
    vec_t v;
    int   w;
    int   g;
    logic [7:0] wb;

    rst_n = 1'b0;
    rdy   = '0;
    bin   = '0;
    clr   = '0;

    // Test 1 and 2 vectors: DIVISOR=2 exhaustive, then DIVISOR=3 spot words.
    for (int i = 0; i < 8; i++) begin
      v = '{inst: 0, word: i, nbits: 3, gap: 1, exp_out: (i % 2 == 0) ? 1 : 0,
            exp_rem: i % 2};
      tbl.push_back(v);
    end
    tbl.push_back('{inst: 1, word: 6, nbits: 3, gap: 2, exp_out: 1, exp_rem: 0});
    tbl.push_back('{inst: 1, word: 7, nbits: 3, gap: 2, exp_out: 0, exp_rem: 1});
    tbl.push_back('{inst: 1, word: 5, nbits: 3, gap: 2, exp_out: 0, exp_rem: 2});

    #2;
    for (int i = 0; i < 4; i++) begin
      check("reset_busy", int'(busy[i]), 0);
      check("reset_valid", int'(valid[i]), 0);
      check("reset_out", int'(outv[i]), 0);
      check("reset_rem", remv[i], 0);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      send_word(tbl[i].inst, tbl[i].word, tbl[i].nbits, tbl[i].gap,
                tbl[i].exp_out, tbl[i].exp_rem);
    end

    // Test 3: continuous ready, 0xFF then 0xFE, DIVISOR=5.
    sb.push_back('{inst: 2, exp_out: 1, exp_rem: 0});
    sb.push_back('{inst: 2, exp_out: 0, exp_rem: 4});
    for (int k = 0; k < 16; k++) begin
      wb = (k < 8) ? 8'hFF : 8'hFE;
      rdy[2] = 1'b1;
      bin[2] = wb[7 - (k % 8)];
      tick();
      check("stream_valid", int'(valid[2]), (k % 8 == 7) ? 1 : 0);
      check("stream_busy", int'(busy[2]), (k % 8 == 7) ? 0 : 1);
    end
    rdy[2] = 1'b0;
    tick();
    check("stream_valid_end", int'(valid[2]), 0);

    // Test 4: abort after 1,1 with clear colliding with a ready bit.
    rdy[1] = 1'b1;
    bin[1] = 1'b1;
    tick();
    tick();
    check("abort_busy_before", int'(busy[1]), 1);
    clr[1] = 1'b1;
    bin[1] = 1'b0;
    tick();
    clr[1] = 1'b0;
    rdy[1] = 1'b0;
    check("abort_busy", int'(busy[1]), 0);
    check("abort_valid", int'(valid[1]), 0);
    check("abort_out_held", int'(outv[1]), 0);
    check("abort_rem_held", remv[1], 2);
    tick();
    check("abort_no_valid", int'(valid[1]), 0);
    send_word(1, 1, 3, 1, 0, 1);

    // Test 5: asynchronous reset mid-word and during a valid pulse.
    rdy[1] = 1'b1;
    bin[1] = 1'b1;
    tick();
    bin[1] = 1'b0;
    tick();
    rdy[1] = 1'b0;
    rdy[0] = 1'b1;
    bin[0] = 1'b1;
    tick();
    tick();
    bin[0] = 1'b0;
    tick();
    rdy[0] = 1'b0;
    check("pre_reset_busy", int'(busy[1]), 1);
    check("pre_reset_valid", int'(valid[0]), 1);
    check("pre_reset_out", int'(outv[0]), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_busy", int'(busy[1]), 0);
    check("async_valid", int'(valid[0]), 0);
    check("async_out", int'(outv[0]), 0);
    check("async_rem", remv[1], 0);
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    send_word(1, 3, 3, 1, 1, 0);

    // Test 6: random words with random ready gaps, DIVISOR=7, WORD_BITS=6.
    for (int n = 0; n < 200; n++) begin
      w = int'($urandom_range(0, 63));
      g = int'($urandom_range(0, 4));
      send_word(3, w, 6, g, (w % 7 == 0) ? 1 : 0, w % 7);
    end
    rdy[3] = 1'b0;
    tick();
    tick();
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
